// File: rtl/ram_array_read_sequencer_pkg.sv
// Shared definitions for the bias-read RAM array read sequencer: FSM encoding,
// default read latency and the last-address calculation used at job start.
package ram_array_read_sequencer_pkg;

    localparam int READ_LATENCY_DEFAULT = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Final relative address of a job; skew adds one extra row per active bank beyond the first.
    function automatic int calc_last(input int rows, input int cols, input logic skew,
                                     input int array_size);
        int ec;
        ec = (cols < array_size) ? cols : array_size;
        return rows - 1 + (skew ? ec - 1 : 0);
    endfunction

endpackage

// File: rtl/ram_array_read_sequencer_if.sv
// Job/control and RAM-array read bundle between the task FSM, the sequencer and the RAM array.
interface ram_array_read_sequencer_if #(
    parameter int ADDR_WIDTH          = 12,
    parameter int RAM_INDEX_ADDR_SIZE = 8
);
    logic                           start;
    logic [ADDR_WIDTH-1:0]          cfg_start_addr;
    logic [RAM_INDEX_ADDR_SIZE-1:0] cfg_rows;
    logic [RAM_INDEX_ADDR_SIZE-1:0] cfg_cols;
    logic                           cfg_skew;
    logic                           stall;
    logic                           busy;
    logic                           done;
    logic                           read_req;
    logic [ADDR_WIDTH-1:0]          read_addr;
    logic [ADDR_WIDTH-1:0]          read_start_addr;
    logic [RAM_INDEX_ADDR_SIZE-1:0] max_addr_size;
    logic [RAM_INDEX_ADDR_SIZE-1:0] max_ram_size;
    logic                           addr_bias;
    logic                           data_valid;
    logic                           data_last;

    modport master (
        output start, cfg_start_addr, cfg_rows, cfg_cols, cfg_skew, stall,
        input  busy, done, read_req, read_addr, read_start_addr, max_addr_size,
               max_ram_size, addr_bias, data_valid, data_last
    );

    modport slave (
        input  start, cfg_start_addr, cfg_rows, cfg_cols, cfg_skew, stall,
        output busy, done, read_req, read_addr, read_start_addr, max_addr_size,
               max_ram_size, addr_bias, data_valid, data_last
    );
endinterface

// File: rtl/ram_array_read_sequencer_valid_delay_line.sv
// DEPTH-stage shift register carrying {valid, last} so the strobes line up with RAM read data.
module valid_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic valid_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o
);
    generate
        if (DEPTH == 0) begin : g_pass
            assign valid_o = valid_i;
            assign last_o  = last_i;
        end else begin : g_pipe
            logic [DEPTH-1:0] valid_q;
            logic [DEPTH-1:0] last_q;

            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    valid_q <= '0;
                    last_q  <= '0;
                end else begin
                    valid_q[0] <= valid_i;
                    last_q[0]  <= last_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        last_q[i]  <= last_q[i-1];
                    end
                end
            end

            assign valid_o = valid_q[DEPTH-1];
            assign last_o  = last_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/ram_array_read_sequencer.sv
// Read-side sequencer for the bias-read RAM array: latches a job, issues addresses 0..LAST
// one per unstalled cycle, aligns valid/last with the read data and pulses done.
module ram_array_read_sequencer
    import ram_array_read_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH          = 12,
    parameter int ARRAY_SIZE          = 8,
    parameter int RAM_INDEX_ADDR_SIZE = 8,
    parameter int READ_LATENCY        = READ_LATENCY_DEFAULT
) (
    input logic                  clk,
    input logic                  reset_n,
    ram_array_read_sequencer_if.slave bus
);
    localparam int DRAIN_W = $clog2(READ_LATENCY + 1) + 1;

    logic [1:0]                     state_q, state_d;
    logic [ADDR_WIDTH:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]            last_q, last_d;
    logic [DRAIN_W-1:0]             drain_q, drain_d;
    logic                           read_req_q, read_req_d;
    logic                           read_last_q, read_last_d;
    logic [ADDR_WIDTH-1:0]          read_addr_q, read_addr_d;
    logic [ADDR_WIDTH-1:0]          start_addr_q, start_addr_d;
    logic [RAM_INDEX_ADDR_SIZE-1:0] rows_q, rows_d;
    logic [RAM_INDEX_ADDR_SIZE-1:0] cols_q, cols_d;
    logic                           skew_q, skew_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        drain_d      = drain_q;
        read_req_d   = 1'b0;
        read_last_d  = 1'b0;
        read_addr_d  = read_addr_q;
        start_addr_d = start_addr_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        skew_d       = skew_q;

        case (state_q)
            ST_IDLE: begin
                read_addr_d = '0;
                cnt_d       = '0;
                if (bus.start) begin
                    start_addr_d = bus.cfg_start_addr;
                    rows_d       = bus.cfg_rows;
                    cols_d       = bus.cfg_cols;
                    skew_d       = bus.cfg_skew;
                    last_d       = (ADDR_WIDTH+1)'(calc_last(int'(bus.cfg_rows), int'(bus.cfg_cols),
                                                             bus.cfg_skew, ARRAY_SIZE));
                    drain_d      = '0;
                    state_d      = (bus.cfg_rows == '0 || bus.cfg_cols == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    read_req_d  = 1'b1;
                    read_addr_d = cnt_q[ADDR_WIDTH-1:0];
                    read_last_d = (cnt_q == last_q);
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == last_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave once the final beat has reached the delay-line output.
                read_addr_d = '0;
                if (drain_q == DRAIN_W'(READ_LATENCY)) state_d = ST_DONE;
                else                                   drain_d = drain_q + 1'b1;
            end
            ST_DONE: begin
                read_addr_d = '0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_q       <= '0;
            drain_q      <= '0;
            read_req_q   <= 1'b0;
            read_last_q  <= 1'b0;
            read_addr_q  <= '0;
            start_addr_q <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            skew_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            drain_q      <= drain_d;
            read_req_q   <= read_req_d;
            read_last_q  <= read_last_d;
            read_addr_q  <= read_addr_d;
            start_addr_q <= start_addr_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            skew_q       <= skew_d;
        end
    end

    valid_delay_line #(
        .DEPTH(READ_LATENCY)
    ) u_valid_delay_line (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (read_req_q),
        .last_i  (read_last_q),
        .valid_o (bus.data_valid),
        .last_o  (bus.data_last)
    );

    assign bus.busy            = (state_q != ST_IDLE);
    assign bus.done            = (state_q == ST_DONE);
    assign bus.read_req        = read_req_q;
    assign bus.read_addr       = read_addr_q;
    assign bus.read_start_addr = start_addr_q;
    assign bus.max_addr_size   = rows_q;
    assign bus.max_ram_size    = cols_q;
    assign bus.addr_bias       = skew_q;
endmodule

// File: tb/tb_ram_array_read_sequencer.sv
// Self-checking bench: directed and random jobs checked cycle by cycle against a behavioural model.
module tb_ram_array_read_sequencer;
    localparam int AW = 12;
    localparam int RW = 8;
    localparam int AS = 8;
    localparam int RL = 1;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    ram_array_read_sequencer_if #(.ADDR_WIDTH(AW), .RAM_INDEX_ADDR_SIZE(RW)) bus ();

    ram_array_read_sequencer #(
        .ADDR_WIDTH(AW), .ARRAY_SIZE(AS), .RAM_INDEX_ADDR_SIZE(RW), .READ_LATENCY(RL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic randomize_cfg();
        bus.cfg_start_addr = AW'($urandom);
        bus.cfg_rows       = RW'($urandom);
        bus.cfg_cols       = RW'($urandom);
        bus.cfg_skew       = 1'($urandom);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},       bus.busy,            0);
        check({pfx, "_done"},       bus.done,            0);
        check({pfx, "_read_req"},   bus.read_req,        0);
        check({pfx, "_read_addr"},  bus.read_addr,       0);
        check({pfx, "_start_addr"}, bus.read_start_addr, 0);
        check({pfx, "_max_addr"},   bus.max_addr_size,   0);
        check({pfx, "_max_ram"},    bus.max_ram_size,    0);
        check({pfx, "_addr_bias"},  bus.addr_bias,       0);
        check({pfx, "_valid"},      bus.data_valid,      0);
        check({pfx, "_last"},       bus.data_last,       0);
    endtask

    // stall_mode: 0 none, 1 random, 2 three-cycle stall while address 2 is pending.
    task automatic run_job(input int rows, input int cols, input logic skew, input int saddr,
                           input int stall_mode, input logic extra_starts, output int n_req);
        int   ec, last, exp_addr, n_valid, prev_addr, stall_left;
        logic empty, prev_req, prev_lastbeat, stall_applied, finished;
        ec    = (cols < AS) ? cols : AS;
        last  = rows - 1 + (skew ? ec - 1 : 0);
        empty = (rows == 0) || (cols == 0);

        @(negedge clk);
        bus.start          = 1'b1;
        bus.cfg_start_addr = AW'(saddr);
        bus.cfg_rows       = RW'(rows);
        bus.cfg_cols       = RW'(cols);
        bus.cfg_skew       = skew;
        bus.stall          = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        randomize_cfg();

        exp_addr = 0; n_req = 0; n_valid = 0; prev_addr = 0; stall_left = 0;
        prev_req = 1'b0; prev_lastbeat = 1'b0; stall_applied = 1'b0; finished = 1'b0;

        for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
            logic e_req, e_valid, e_last, e_done;
            e_req   = (cyc > 0) && !stall_applied && !empty && (exp_addr <= last);
            e_valid = prev_req;
            e_last  = prev_req && (prev_addr == last);
            e_done  = empty ? (cyc == 0) : prev_lastbeat;

            check("busy",       bus.busy,       1);
            check("done",       bus.done,       e_done);
            check("read_req",   bus.read_req,   e_req);
            if (e_req) check("read_addr", bus.read_addr, exp_addr);
            check("data_valid", bus.data_valid, e_valid);
            check("data_last",  bus.data_last,  e_last);
            check("start_addr", bus.read_start_addr, saddr);
            check("max_addr",   bus.max_addr_size,   rows);
            check("max_ram",    bus.max_ram_size,    cols);
            check("addr_bias",  bus.addr_bias,       skew);
            if (bus.read_req)   n_req++;
            if (bus.data_valid) n_valid++;

            if (stall_mode == 2 && e_req && exp_addr == 1) stall_left = 3;
            prev_lastbeat = e_last;
            prev_req      = e_req;
            prev_addr     = exp_addr;
            if (e_req) exp_addr++;

            if (e_done) begin
                finished  = 1'b1;
                bus.start = 1'b0;
                bus.stall = 1'b0;
            end else begin
                case (stall_mode)
                    1:       bus.stall = ($urandom_range(0, 3) == 0);
                    2:       bus.stall = (stall_left > 0);
                    default: bus.stall = 1'b0;
                endcase
                if (stall_left > 0) stall_left--;
                bus.start = extra_starts && ($urandom_range(0, 2) == 0);
                randomize_cfg();
                stall_applied = bus.stall;
                @(posedge clk);
                #1;
            end
        end

        check("job_finished", finished, 1);
        check("req_count",   n_req,   empty ? 0 : last + 1);
        check("valid_count", n_valid, empty ? 0 : last + 1);

        @(posedge clk);
        #1;
        check("idle_busy",      bus.busy,      0);
        check("idle_done",      bus.done,      0);
        check("idle_read_req",  bus.read_req,  0);
        check("idle_read_addr", bus.read_addr, 0);
    endtask

    initial begin
        int   n;
        logic hit;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        randomize_cfg();
        #1;
        check_all_zero("rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run_job(4, 8, 1'b1, 'h040, 0, 1'b0, n);
        check("skew_len", n, 11);
        run_job(4, 3, 1'b0, 'h100, 0, 1'b0, n);
        check("noskew_len", n, 4);
        run_job(2, 12, 1'b1, 'h0a5, 0, 1'b0, n);
        check("clamp_len", n, 9);
        run_job(6, 4, 1'b1, 'h200, 2, 1'b1, n);
        check("stall_len", n, 9);
        run_job(0, 5, 1'b0, 'h010, 1, 1'b0, n);
        run_job(3, 0, 1'b1, 'h020, 1, 1'b0, n);

        for (int j = 0; j < 20; j++) begin
            run_job($urandom_range(0, 20), $urandom_range(0, 15), 1'($urandom),
                    int'(AW'($urandom)), 1, 1'($urandom), n);
        end

        // Abort a job while address 5 is on the bus.
        @(negedge clk);
        bus.start          = 1'b1;
        bus.cfg_start_addr = 12'h3ff;
        bus.cfg_rows       = 8'd8;
        bus.cfg_cols       = 8'd2;
        bus.cfg_skew       = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (bus.read_req && bus.read_addr == 5) hit = 1'b1;
        end
        check("abort_reached_addr5", hit, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(posedge clk);
        #1;
        check_all_zero("abort_hold");
        @(negedge clk);
        reset_n = 1'b1;
        run_job(5, 8, 1'b1, 'h155, 0, 1'b0, n);
        check("post_reset_len", n, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_array_read_sequencer.md
Name: ram_array_read_sequencer

Overview:
- Controller that drives the read side of the bias-read RAM array feeding the systolic array.
- On a start pulse it latches a job (start address, row count, active columns, skew mode) and streams read addresses 0..LAST, one per cycle, with stall support.
- Produces a valid/last strobe aligned with the RAM array's read data, then a done pulse.
- Sits between the top-level task FSM and the RAM array's read_req/read_addr/read_start_addr/addr_bias/max_addr_size/max_ram_size inputs.

Parameters:
- ADDR_WIDTH, 12, RAM address width; must match the RAM array.
- ARRAY_SIZE, 8, number of RAM banks (columns).
- RAM_INDEX_ADDR_SIZE, 8, width of the row-count and column-count fields.
- READ_LATENCY, 1, cycles from read_req to read_data; 1 when the array's OUTPUT_REG=1, 0 when OUTPUT_REG=0.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job request; honoured only in IDLE.
- cfg_start_addr  in  ADDR_WIDTH  base address of the job.
- cfg_rows  in  RAM_INDEX_ADDR_SIZE  rows per bank (max_addr_size).
- cfg_cols  in  RAM_INDEX_ADDR_SIZE  active banks (max_ram_size).
- cfg_skew  in  1  1 = diagonal skew (addr_bias=1).
- stall  in  1  downstream hold; freezes address issue.
- busy  out  1  high from the accepted start through the done cycle.
- done  out  1  one-cycle pulse when the job completes.
- read_req  out  1  to the RAM array.
- read_addr  out  ADDR_WIDTH  relative address to the RAM array.
- read_start_addr, max_addr_size, max_ram_size, addr_bias  out  -  latched configuration to the RAM array.
- data_valid  out  1  RAM array read_data is valid this cycle.
- data_last  out  1  qualifies the final data_valid beat.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All outputs go to 0, including the latched configuration registers and the valid/last pipeline.
- Effective columns: EC = min(cfg_cols, ARRAY_SIZE).
- Last address: LAST = cfg_rows - 1 + (cfg_skew ? EC - 1 : 0).
  - Computed at start in ADDR_WIDTH+1 bits.
  - Latched, together with all cfg_* fields.
- States:
  - IDLE: start=1 latches the configuration. Go to RUN, or to DONE if cfg_rows==0 or cfg_cols==0 (no reads are issued).
  - RUN:
    - If stall=0: read_req=1 and read_addr=cnt; cnt increments. When cnt==LAST is issued, go to DRAIN.
    - If stall=1: read_req=0 and cnt holds.
  - DRAIN: wait until the valid pipeline is empty (READ_LATENCY cycles after the last issue; zero cycles if READ_LATENCY=0), then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- read_req and read_addr are registered outputs. The first read_req appears the cycle after start is accepted.
- Valid alignment:
  - data_valid = read_req delayed by READ_LATENCY cycles (shift register; combinational passthrough when READ_LATENCY=0).
  - data_last follows the same delay and marks the beat where read_addr==LAST.
- busy=1 in RUN, DRAIN and DONE.
- start while busy is ignored. The latched configuration stays stable for the whole job.
- stall in IDLE, DRAIN or DONE has no effect.
- A stall in RUN creates gaps in data_valid. It never drops or repeats an address.
- read_addr returns to 0 when in IDLE.
- Reset mid-job aborts immediately: no done pulse and no further read_req.
- Throughput: with no stalls, a job takes LAST+1 issue cycles + READ_LATENCY + 1 done cycle.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, RUN, DRAIN, DONE);
  - the READ_LATENCY default;
  - a function computing LAST from rows, cols, skew and ARRAY_SIZE.
- One natural sub-module: valid_delay_line, a parameterised READ_LATENCY-deep shift register carrying {valid, last}, reset to 0, with passthrough at depth 0.

Test Plan:
- Skewed job, READ_LATENCY=1: start, cfg_rows=4, cfg_cols=8, cfg_skew=1, no stall.
  - read_addr must go 0..10 on 11 consecutive read_req cycles.
  - data_valid must be high for 11 cycles, starting 1 cycle after the first read_req.
  - data_last must be set on the 11th valid beat; done follows 1 cycle later.
- Unskewed job: cfg_rows=4, cfg_cols=3, cfg_skew=0, cfg_start_addr=0x100.
  - Addresses must be 0..3.
  - read_start_addr must stay 0x100 throughout; addr_bias must be 0 and max_ram_size 3.
- Column clamp: cfg_cols=12, cfg_skew=1, cfg_rows=2 -> LAST must be 8 (EC clamped to 8).
- Stall: stall=1 while read_addr=2 is pending, for 3 cycles.
  - read_req must be 0 for 3 cycles and no address may be skipped.
  - Total data_valid count must equal LAST+1.
  - start pulses during the job must be ignored.
- Empty job: cfg_rows=0 -> no read_req; busy high and done pulses exactly 1 cycle after start.
- Reset mid-job: drop reset_n while read_addr=5 -> all outputs 0 immediately and state IDLE. A fresh start after reset release must run a complete new job.
